uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Buffers and serialises the byte-output stream the RV32IM core emits on its 9-bit uart_out bus.
//  uart_out is bit8 = write strobe, [7:0] = data.
//  Absorbs bursts from the 3-issue core in a FIFO and schedules bytes onto a single 8N1 serial line.
//  Reports fill level and overflow so the test harness and software can detect lost characters.
// PARAMETERS
//  CLK_DIV     16  clock cycles per serial bit; legal range 2..65535
//  FIFO_DEPTH  16  FIFO entries; must be a power of 2, at least 2
//  FIFO_AW     4   log2(FIFO_DEPTH)
// PORTS
//  clock       in   1          rising-edge clock
//  reset_n     in   1          synchronous reset, active low
//  uart_in     in   9          [8] = push strobe (one byte per cycle it is high), [7:0] = byte
//  ovf_clr     in   1          clears the sticky overflow flag
//  tx          out  1          serial line, idle high
//  busy        out  1          high while a frame is on the line (any state except IDLE)
//  tx_done     out  1          one-cycle pulse in the last cycle of each stop bit
//  fifo_empty  out  1          count == 0
//  fifo_full   out  1          count == FIFO_DEPTH
//  fifo_count  out  FIFO_AW+1  entries held; excludes the byte currently shifting
//  overflow    out  1          sticky: set when a push arrives while full
// BEHAVIOUR
//  Reset: while reset_n=0 at a rising edge, the following values are loaded:
//   tx=1, busy=0, tx_done=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0.
//   Pointers, bit counter and baud counter are 0; the FSM is IDLE.
//   Reset mid-frame aborts the frame immediately (tx=1 next cycle) and discards the FIFO contents.
//  FIFO:
//   - Push when uart_in[8]=1 and fifo_full=0; data is written at the write pointer, which wraps modulo FIFO_DEPTH.
//   - Push while fifo_full=1 drops the byte and sets overflow.
//   - fullness uses the pre-edge count, so push+pop in the same cycle while full is still rejected.
//   - Push and pop in the same cycle when not full: count unchanged, both pointers advance.
//   - overflow set and ovf_clr in the same cycle: set wins.
//   - All status outputs are registered and valid the cycle after the edge that changed them.
//  FSM (all outputs registered):
//   IDLE:   tx=1. If fifo_empty=0, pop the head byte into the shift register -> START.
//   START:  tx=0 for CLK_DIV cycles -> DATA.
//   DATA:   8 bits, LSB first, each held CLK_DIV cycles; the bit counter runs 0..7 -> PARITY (if enabled) else STOP.
//   PARITY: tx = even parity of the byte, held CLK_DIV cycles -> STOP.
//   STOP:   tx=1 for CLK_DIV cycles; tx_done pulses in the final cycle -> IDLE.
//  Latency:
//   - A push at edge N makes fifo_empty=0 after edge N.
//   - With the FSM idle, the pop occurs at edge N+1 and tx falls after edge N+1.
//   - Push to start bit: 2 cycles.
//  Back-to-back: IDLE spends exactly one cycle between frames (stop -> IDLE -> START).
//   Frame period = 10*CLK_DIV+1 cycles (11*CLK_DIV+1 with parity).
//  The baud counter counts 0..CLK_DIV-1 and resets on every state change; no fractional divide.
//  uart_in[7:0] is ignored whenever uart_in[8]=0.
// CONFIGURATION
//  UART_TX_PARITY_EN
//   Defined: PARITY state present; frame is 8E1 (start, 8 data, even parity, stop).
//   Undefined: PARITY state and parity logic are absent; frame is 8N1; DATA goes straight to STOP.
// TESTING (bench uses CLK_DIV=4, FIFO_DEPTH=4)
//  1. Reset for 3 cycles, then release -> tx=1, busy=0, fifo_empty=1, fifo_count=0, overflow=0.
//  2. Push 0x55 once from idle.
//     -> tx low 2 cycles after the push, for 4 cycles.
//     -> Data bits 1,0,1,0,1,0,1,0, each 4 cycles.
//     -> Stop bit 1 for 4 cycles; tx_done pulses once, 40 cycles after tx fell.
//  3. Push 0x41,0x42,0x43 on consecutive cycles.
//     -> fifo_count reaches 2; frames go out in order with 1 idle cycle between them.
//     -> fifo_empty=1 after the third pop.
//  4. Push 6 bytes consecutively while idle.
//     -> The first is popped, 4 fill the FIFO, the 6th is dropped and overflow=1.
//     -> ovf_clr for 1 cycle makes overflow=0.
//  5. Assert reset_n=0 in the middle of the DATA state with 2 bytes queued.
//     -> Next cycle: tx=1, busy=0, fifo_count=0; no further frames.
//  6. UART_TX_PARITY_EN defined, push 0x07 -> parity bit = 1; frame is 44 cycles; tx_done at the end of stop.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Buffers the core's byte-output stream (uart_in[8] = strobe, [7:0] = byte)
//   in a FIFO and serialises it onto one UART line, idle high, LSB first.
//   It reports the FIFO fill level and a sticky overflow flag.
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> 8E1 frames (PARITY state present)
//     undefined -> 8N1 frames
module uart_tx_scheduler #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [8:0]       uart_in,
  input  logic             ovf_clr,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow
);

  localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  // FIFO storage and status
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_empty;
  logic               r_full;
  logic               r_overflow;

  // Serialiser state
  state_t             r_state;
  logic [15:0]        r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_byte;
  logic               r_tx;
  logic               r_busy;
  logic               r_tx_done;

  // Combinational next-state values
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic [FIFO_AW:0]   w_count_next;
  state_t             w_state_next;
  logic [15:0]        w_baud_next;
  logic [2:0]         w_bit_next;
  logic               w_baud_last;
  logic               w_tx_next;
  logic               w_busy_next;
  logic               w_done_next;
`ifdef UART_TX_PARITY_EN
  logic               w_parity;
`endif

  // Fullness and emptiness are taken from the pre-edge registered flags,
  // so push+pop while full still rejects the push.
  assign w_push = uart_in[8] & ~r_full;
  assign w_drop = uart_in[8] & r_full;

`ifdef UART_TX_PARITY_EN
  assign w_parity = ^r_byte;
`endif

  // FIFO occupancy after this edge
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // FIFO data array; contents need no reset because the pointers gate every read
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= uart_in[7:0];
    end
  end

  // FIFO pointers, count and registered status flags
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == DEPTH_CNT);
    end
  end

  // Sticky overflow; a new drop outranks a clear in the same cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Serialiser next state, counters and the output values for the next cycle
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud + 16'd1;
    w_bit_next   = r_bit;
    w_pop        = 1'b0;
    w_baud_last  = (r_baud == BAUD_LAST);

    unique case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (!r_empty) begin
          w_pop        = 1'b1;
          w_bit_next   = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (r_bit == 3'd7) begin
            w_bit_next   = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_baud_next  = '0;
        w_bit_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state;
    // this puts the start bit on the line in the cycle right after the pop.
    w_busy_next = (w_state_next != S_IDLE);
    w_done_next = (w_state_next == S_STOP) && (w_baud_next == BAUD_LAST);
    w_tx_next   = 1'b1;
    unique case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_byte[w_bit_next];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = w_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Serialiser state register and registered line outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit     <= w_bit_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
      r_tx_done <= w_done_next;
    end
  end

  // Shift byte captured from the FIFO head on each pop
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_byte <= '0;
    end else if (w_pop) begin
      r_byte <= r_mem[r_rptr];
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign tx_done    = r_tx_done;
  assign fifo_empty = r_empty;
  assign fifo_full  = r_full;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with CLK_DIV=4, FIFO_DEPTH=4.
// Inputs are driven and outputs sampled on the falling edge.
module tb_uart_tx_scheduler;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 44;
`else
  localparam int FRAME = 40;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [8:0] uart_in;
  logic       ovf_clr;
  logic       tx;
  logic       busy;
  logic       tx_done;
  logic       fifo_empty;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler #(
    .CLK_DIV   (4),
    .FIFO_DEPTH(4),
    .FIFO_AW   (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .uart_in   (uart_in),
    .ovf_clr   (ovf_clr),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks {tx,busy,tx_done} for every cycle of one frame, from cycle index
  // 'first' (0 = first start-bit cycle) to the last stop-bit cycle.
  task automatic frame_check(input logic [7:0] b, input int first);
    logic e_tx;
    for (int i = first; i < FRAME; i++) begin
      if (i != first) @(negedge clock);
      if (i < 4)       e_tx = 1'b0;
      else if (i < 36) e_tx = b[(i - 4) / 4];
      else if (i < FRAME - 4) e_tx = ^b;
      else             e_tx = 1'b1;
      check($sformatf("frame%02h_c%0d", b, i), {29'd0, tx, busy, tx_done},
            {29'd0, e_tx, 1'b1, (i == FRAME - 1)});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    logic [2:0] e_cnt  [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       e_full [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       e_ovf  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    uart_in = '0;
    ovf_clr = 1'b0;

    // 1. reset
    repeat (3) @(negedge clock);
    check("rst_in_tx", {31'd0, tx}, 32'd1);
    check("rst_in_status", {27'd0, busy, tx_done, fifo_empty, fifo_full, overflow}, 32'b00100);
    check("rst_in_count", {29'd0, fifo_count}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_out_status", {26'd0, tx, busy, tx_done, fifo_empty, fifo_full, overflow}, 32'b100100);
    check("rst_out_count", {29'd0, fifo_count}, 32'd0);

    // 2. single byte 0x55
    uart_in = 9'h155;
    @(negedge clock);
    uart_in = '0;
    check("t2_after_push", {28'd0, tx, busy, fifo_empty, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("t2_count1", {29'd0, fifo_count}, 32'd1);
    @(negedge clock);
    check("t2_popped_empty", {31'd0, fifo_empty}, 32'd1);
    frame_check(8'h55, 0);
    @(negedge clock);
    check("t2_idle_after", {30'd0, tx, busy}, 32'b10);

    // 3. three back-to-back pushes
    uart_in = 9'h141;
    @(negedge clock);
    uart_in = 9'h142;
    check("t3_cnt_e1", {29'd0, fifo_count}, 32'd1);
    @(negedge clock);
    uart_in = 9'h143;
    check("t3_cnt_e2", {29'd0, fifo_count}, 32'd1);
    check("t3_start41", {30'd0, tx, busy}, 32'b01);
    @(negedge clock);
    uart_in = '0;
    check("t3_cnt_e3", {29'd0, fifo_count}, 32'd2);
    frame_check(8'h41, 1);
    @(negedge clock);
    check("t3_gap1", {29'd0, tx, busy, fifo_empty}, 32'b100);
    check("t3_gap1_cnt", {29'd0, fifo_count}, 32'd2);
    @(negedge clock);
    check("t3_cnt_pop2", {29'd0, fifo_count}, 32'd1);
    frame_check(8'h42, 0);
    @(negedge clock);
    check("t3_gap2", {30'd0, tx, busy}, 32'b10);
    @(negedge clock);
    check("t3_empty_pop3", {31'd0, fifo_empty}, 32'd1);
    check("t3_cnt_pop3", {29'd0, fifo_count}, 32'd0);
    frame_check(8'h43, 0);
    @(negedge clock);
    check("t3_idle_end", {29'd0, tx, busy, fifo_empty}, 32'b101);

`ifdef UART_TX_PARITY_EN
    // 6. parity frame, 0x07 has odd weight so the even-parity bit is 1
    uart_in = 9'h107;
    @(negedge clock);
    uart_in = '0;
    @(negedge clock);
    frame_check(8'h07, 0);
    @(negedge clock);
    check("t6_idle_end", {30'd0, tx, busy}, 32'b10);
`endif

    // 4. six pushes while idle: one popped, four stored, sixth dropped
    for (int k = 0; k < 6; k++) begin
      uart_in = {1'b1, 8'(8'h10 + k)};
      ovf_clr = (k == 5);
      @(negedge clock);
      check($sformatf("t4_cnt_e%0d", k + 1), {29'd0, fifo_count}, {29'd0, e_cnt[k]});
      check($sformatf("t4_flags_e%0d", k + 1), {30'd0, fifo_full, overflow},
            {30'd0, e_full[k], e_ovf[k]});
    end
    uart_in = '0;
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
    check("t4_still_full", {28'd0, fifo_count, fifo_full}, {28'd0, 3'd4, 1'b1});
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("t4_flush", {27'd0, fifo_count, fifo_empty, busy}, {27'd0, 3'd0, 1'b1, 1'b0});

    // 5. reset in the middle of DATA with two bytes queued
    @(negedge clock);
    uart_in = 9'h1A5;
    @(negedge clock);
    uart_in = 9'h13C;
    @(negedge clock);
    uart_in = 9'h10F;
    @(negedge clock);
    uart_in = '0;
    repeat (9) @(negedge clock);
    check("t5_pre_cnt", {29'd0, fifo_count}, 32'd2);
    check("t5_pre_busy", {31'd0, busy}, 32'd1);
    check("t5_pre_bit", {31'd0, tx}, 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("t5_abort", {27'd0, tx, busy, fifo_count}, {27'd0, 1'b1, 1'b0, 3'd0});
    check("t5_empty", {31'd0, fifo_empty}, 32'd1);
    act = 0;
    repeat (60) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) act++;
    end
    check("t5_no_frames", act, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
